// File: rtl/fifo_pkg.sv
// Shared helpers for the fifo_sync slice: width functions, flag bundle, reset values
// and parameter legality checks used at elaboration.
package fifo_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic af;
        logic ae;
    } fifo_flags_t;

    // An empty FIFO is always "almost empty" (AE_LEVEL >= 0) and never "almost full" (AF_LEVEL >= 1).
    localparam fifo_flags_t RST_FLAGS = '{full: 1'b0, empty: 1'b1, af: 1'b0, ae: 1'b1};
    localparam logic        RST_RD_DV = 1'b0;
    localparam logic        RST_ERR   = 1'b0;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit params_legal(input int width, input int depth,
                                        input int af_level, input int ae_level);
        return (width >= 1) && (depth >= 4) && is_pow2(depth) &&
               (af_level >= 1) && (af_level <= depth) &&
               (ae_level >= 0) && (ae_level <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Single-clock simple-dual-port memory, WIDTH x DEPTH, with a registered read port.
// The read register holds its value when no read is requested.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst_L,
    input  logic                        i_Wr_En,
    input  logic [ptr_width(DEPTH)-1:0] i_Wr_Addr,
    input  logic [WIDTH-1:0]            i_Wr_Data,
    input  logic                        i_Rd_En,
    input  logic [ptr_width(DEPTH)-1:0] i_Rd_Addr,
    output logic [WIDTH-1:0]            o_Rd_Data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it can map onto block RAM; stale words are never read.
    always_ff @(posedge i_Clk) begin
        if (i_Wr_En) begin
            mem[i_Wr_Addr] <= i_Wr_Data;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Rd_Data <= '0;
        end else if (i_Rd_En) begin
            o_Rd_Data <= mem[i_Rd_Addr];
        end
    end

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with occupancy count, registered flags and a 1-cycle read data-valid strobe.
// Define FIFO_ERR_FLAGS_EN to build sticky overflow/underflow flags; otherwise they are tied to 0.
module fifo_sync
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 256,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst_L,
    input  logic                        i_Wr_DV,
    input  logic [WIDTH-1:0]            i_Wr_Data,
    input  logic                        i_Rd_En,
    output logic                        o_Rd_DV,
    output logic [WIDTH-1:0]            o_Rd_Data,
    output logic [cnt_width(DEPTH)-1:0] o_Count,
    output logic                        o_Full,
    output logic                        o_Empty,
    output logic                        o_AF,
    output logic                        o_AE,
    output logic                        o_Overflow,
    output logic                        o_Underflow
);

    localparam int CW = cnt_width(DEPTH);
    localparam int PW = ptr_width(DEPTH);

    if (!params_legal(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
        $error("fifo_sync: illegal parameters (DEPTH must be a power of two >= 4, AF_LEVEL in 1..DEPTH, AE_LEVEL in 0..DEPTH-1)");
    end

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    fifo_flags_t   flags;
    fifo_flags_t   flags_next;
    logic          rd_dv;
    logic          wr_ok;
    logic          rd_ok;

    // Requests are gated by the registered flags only; there is no write-to-read bypass.
    assign wr_ok = i_Wr_DV & ~flags.full;
    assign rd_ok = i_Rd_En & ~flags.empty;

    always_comb begin
        count_next = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase

        flags_next       = RST_FLAGS;
        flags_next.full  = (count_next == CW'(DEPTH));
        flags_next.empty = (count_next == '0);
        flags_next.af    = (count_next >= CW'(AF_LEVEL));
        flags_next.ae    = (count_next <= CW'(AE_LEVEL));
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            flags  <= RST_FLAGS;
            rd_dv  <= RST_RD_DV;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            flags <= flags_next;
            rd_dv <= rd_ok;
        end
    end

    // wr_ptr == rd_ptr with both accepted cannot happen: that needs count 0 or DEPTH.
    fifo_mem #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_mem (
        .i_Clk     (i_Clk),
        .i_Rst_L   (i_Rst_L),
        .i_Wr_En   (wr_ok),
        .i_Wr_Addr (wr_ptr),
        .i_Wr_Data (i_Wr_Data),
        .i_Rd_En   (rd_ok),
        .i_Rd_Addr (rd_ptr),
        .o_Rd_Data (o_Rd_Data)
    );

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow;
    logic underflow;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            overflow  <= RST_ERR;
            underflow <= RST_ERR;
        end else begin
            overflow  <= overflow  | (i_Wr_DV & flags.full);
            underflow <= underflow | (i_Rd_En & flags.empty);
        end
    end

    assign o_Overflow  = overflow;
    assign o_Underflow = underflow;
`else
    assign o_Overflow  = RST_ERR;
    assign o_Underflow = RST_ERR;
`endif

    assign o_Rd_DV = rd_dv;
    assign o_Count = count;
    assign o_Full  = flags.full;
    assign o_Empty = flags.empty;
    assign o_AF    = flags.af;
    assign o_AE    = flags.ae;

endmodule
